vga_pixel_pipe: RTL and testbench
=================================

Name: vga_pixel_pipe

Overview:
- Pixel-generation stage directly downstream of the 640x480 sync generator.
- Consumes pixel_x/pixel_y/video_on/p_tick/hsync/vsync; produces 8-bit RGB (3-3-2) plus re-timed syncs for the DAC pins.
- Draws a selectable background (black, colour bars, checkerboard) with one host-programmable solid rectangle.
- Host writes go through a four-phase req/ack port; writes are shadowed and applied only at the frame boundary, so no tearing.

Parameters:
- HD, 640, horizontal display width in pixels
- VD, 480, vertical display height in lines
- PIPE, 2, pixel-tick pipeline depth; fixed at 2, other values unsupported
- RST_COLOR, 8'hE0, reset value of the rectangle colour (red)

Ports:
- clk  in  1  system clock, same clock as the sync generator
- reset  in  1  asynchronous, active-low reset
- p_tick  in  1  pixel enable from the sync generator; one clk in two
- pixel_x  in  10  current column
- pixel_y  in  10  current line
- video_on  in  1  active-area flag
- hsync_in  in  1  active-low horizontal sync from the sync generator
- vsync_in  in  1  active-low vertical sync from the sync generator
- wr_req  in  1  host write request, level
- wr_addr  in  3  register select
- wr_data  in  10  write data
- wr_ack  out  1  write acknowledge, level
- wr_err  out  1  high with wr_ack when wr_addr is illegal
- rgb  out  8  pixel colour, {R[2:0],G[2:0],B[1:0]}
- hsync  out  1  hsync_in delayed to align with rgb
- vsync  out  1  vsync_in delayed to align with rgb
- frame_cnt  out  8  frames completed since reset, wraps

Behaviour:
- Reset (reset=0, async): rgb=0, hsync=1, vsync=1, wr_ack=0, wr_err=0, frame_cnt=0, all pipeline regs 0/inactive.
- Reset values, active and shadow registers: RX=0, RY=0, RW=0, RH=0, COLOR=RST_COLOR, BG=1.
- Pipeline:
  - All pipeline registers update only on clk edges with p_tick=1.
  - Stage 1 captures x, y, video_on, hsync_in, vsync_in.
  - Stage 2 computes colour from stage-1 values and registers rgb, hsync, vsync.
  - Latency: exactly 2 pixel ticks (4 clk) from input to output. The sync-to-pixel relationship at the input is preserved at the output.
- Colour selection in stage 2, in priority order:
  - Stage-1 video_on=0 -> rgb=0.
  - Inside the rectangle -> COLOR. Inside means RX <= x < RX+RW and RY <= y < RY+RH; sums are computed 11-bit, so there is no wrap.
  - RW=0 or RH=0 means no rectangle. A rectangle extending past HD/VD is clipped naturally by video_on.
  - Otherwise, background by BG:
    - BG=0: black.
    - BG=1: 8 vertical bars of 80 px; bar k (x in [80k, 80k+79]) is white, yellow, cyan, green, magenta, red, blue, black for k=0..7 (FF, FC, 1F, 1C, E3, E0, 03, 00).
    - BG=2: checkerboard; x[5]^y[5] ? FF : 00.
    - BG=3: treated as BG=0.
- Frame boundary event (FB): clk edge with p_tick=1, pixel_x==0 and pixel_y==VD.
  - On FB: all active registers <= shadow registers, and frame_cnt increments.
- Register map: 0 RX, 1 RY, 2 RW, 3 RH (10 bits each), 4 COLOR (wr_data[7:0]), 5 BG (wr_data[1:0]); 6 and 7 are illegal.
- Write FSM, states IDLE and ACK:
  - IDLE, wr_req=1: write shadow[wr_addr] (legal addresses only), set wr_err = illegal, assert wr_ack, go to ACK.
  - ACK: hold wr_ack/wr_err until wr_req=0, then deassert both and return to IDLE.
  - wr_addr/wr_data are sampled only on the IDLE->ACK edge.
- A shadow write on the same edge as FB: FB copies the pre-write shadow value; the new value takes effect at the next FB.
- Reset mid-write: FSM returns to IDLE and the shadow write is lost. The host must restart the handshake.

Optional Feature:
- Macro VGA_PIXEL_BLINK_EN.
- Defined: the rectangle is drawn only when frame_cnt[5]=0; otherwise the background shows through. The blink period is 64 frames.
- Undefined: the rectangle is always drawn. frame_cnt is still implemented and output.

Decomposition:
- Shared package vga_pkg holds:
  - HD, VD, and the sync timing constants
  - register address constants (ADDR_RX..ADDR_BG)
  - BG mode encodings
  - the 8 colour-bar constants
  - the RGB332 field widths
- Natural sub-module: vga_reg_if, containing the write FSM, the shadow registers, and the FB copy into the active registers.

Test Plan:
- Reset release, BG=1: line 0 x=0..639 -> rgb FF for x 0..79, FC for 80..159 … 00 for 560..639. rgb=0 when video_on=0. rgb transitions 2 p_ticks after the pixel_x transition.
- Write RX=100, RY=50, RW=20, RH=10, COLOR=1C mid-frame -> current frame unchanged. From the frame after the next FB, rgb=1C exactly for x 100..119, y 50..59.
- Handshake: raise wr_req with addr 6 -> wr_ack=1, wr_err=1 next clk, held until wr_req drops; no register changes. Addr 4 -> wr_err=0.
- Write RX=630, RW=50 -> rectangle covers x 630..639 only, with no wrap to x 0..39.
- Assert reset for 3 clk during ACK and mid-line -> all outputs at reset values immediately. After release, hsync/vsync follow the inputs with 2-tick delay; frame_cnt=0.
- Run 130 frames with VGA_PIXEL_BLINK_EN defined -> rectangle visible for frames 0..31 and 64..95, absent for 32..63 and 96..127. frame_cnt wraps 255->0 after 256 frames.

Source files
------------

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared constants, encodings and helpers for the VGA pixel pipeline
package vga_pkg;

    localparam int HD      = 640;
    localparam int VD      = 480;
    localparam int H_FP    = 16;
    localparam int H_SYNC  = 96;
    localparam int H_BP    = 48;
    localparam int H_TOTAL = HD + H_FP + H_SYNC + H_BP;
    localparam int V_FP    = 10;
    localparam int V_SYNC  = 2;
    localparam int V_BP    = 33;
    localparam int V_TOTAL = VD + V_FP + V_SYNC + V_BP;

    localparam int COORD_W = 10;
    localparam int R_W     = 3;
    localparam int G_W     = 3;
    localparam int B_W     = 2;
    localparam int RGB_W   = R_W + G_W + B_W;

    localparam logic [2:0] ADDR_RX    = 3'd0;
    localparam logic [2:0] ADDR_RY    = 3'd1;
    localparam logic [2:0] ADDR_RW    = 3'd2;
    localparam logic [2:0] ADDR_RH    = 3'd3;
    localparam logic [2:0] ADDR_COLOR = 3'd4;
    localparam logic [2:0] ADDR_BG    = 3'd5;

    typedef enum logic [1:0] {
        BG_BLACK = 2'd0,
        BG_BARS  = 2'd1,
        BG_CHECK = 2'd2,
        BG_RSVD  = 2'd3
    } bg_mode_t;

    typedef enum logic {
        WR_IDLE = 1'b0,
        WR_ACK  = 1'b1
    } wr_state_t;

    localparam logic [RGB_W-1:0] BAR_WHITE   = 8'hFF;
    localparam logic [RGB_W-1:0] BAR_YELLOW  = 8'hFC;
    localparam logic [RGB_W-1:0] BAR_CYAN    = 8'h1F;
    localparam logic [RGB_W-1:0] BAR_GREEN   = 8'h1C;
    localparam logic [RGB_W-1:0] BAR_MAGENTA = 8'hE3;
    localparam logic [RGB_W-1:0] BAR_RED     = 8'hE0;
    localparam logic [RGB_W-1:0] BAR_BLUE    = 8'h03;
    localparam logic [RGB_W-1:0] BAR_BLACK   = 8'h00;

    // Bar index is found by threshold compares so no divider is inferred.
    function automatic logic [RGB_W-1:0] bar_color(input logic [COORD_W-1:0] x, input int bar_w);
        logic [2:0] k;
        k = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if (x >= COORD_W'(i * bar_w)) k = 3'(i);
        end
        case (k)
            3'd0:    return BAR_WHITE;
            3'd1:    return BAR_YELLOW;
            3'd2:    return BAR_CYAN;
            3'd3:    return BAR_GREEN;
            3'd4:    return BAR_MAGENTA;
            3'd5:    return BAR_RED;
            3'd6:    return BAR_BLUE;
            default: return BAR_BLACK;
        endcase
    endfunction

endpackage

// File: rtl/vga_reg_if.sv
// rtl/vga_reg_if.sv - host write handshake, shadow registers and frame-boundary copy to active set
module vga_reg_if
    import vga_pkg::*;
#(
    parameter logic [7:0] RST_COLOR = 8'hE0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 fb,
    input  logic                 wr_req,
    input  logic [2:0]           wr_addr,
    input  logic [COORD_W-1:0]   wr_data,
    output logic                 wr_ack,
    output logic                 wr_err,
    output logic [COORD_W-1:0]   rx,
    output logic [COORD_W-1:0]   ry,
    output logic [COORD_W-1:0]   rw,
    output logic [COORD_W-1:0]   rh,
    output logic [RGB_W-1:0]     color,
    output logic [1:0]           bg
);

    wr_state_t state, state_nxt;
    logic      wr_en;
    logic      addr_legal;

    logic [COORD_W-1:0] sh_rx, sh_ry, sh_rw, sh_rh;
    logic [RGB_W-1:0]   sh_color;
    logic [1:0]         sh_bg;

    assign addr_legal = (wr_addr <= ADDR_BG);
    assign wr_ack     = (state == WR_ACK);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= WR_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        wr_en     = 1'b0;
        case (state)
            WR_IDLE: begin
                if (wr_req) begin
                    wr_en     = 1'b1;
                    state_nxt = WR_ACK;
                end
            end
            WR_ACK: begin
                if (!wr_req) state_nxt = WR_IDLE;
            end
            default: state_nxt = WR_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_err <= 1'b0;
        end else if (wr_en) begin
            wr_err <= !addr_legal;
        end else if (state == WR_ACK && !wr_req) begin
            wr_err <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sh_rx    <= '0;
            sh_ry    <= '0;
            sh_rw    <= '0;
            sh_rh    <= '0;
            sh_color <= RST_COLOR;
            sh_bg    <= BG_BARS;
        end else if (wr_en) begin
            case (wr_addr)
                ADDR_RX:    sh_rx    <= wr_data;
                ADDR_RY:    sh_ry    <= wr_data;
                ADDR_RW:    sh_rw    <= wr_data;
                ADDR_RH:    sh_rh    <= wr_data;
                ADDR_COLOR: sh_color <= wr_data[RGB_W-1:0];
                ADDR_BG:    sh_bg    <= wr_data[1:0];
                default:    ;
            endcase
        end
    end

    // Active set reads the shadows before any same-edge write lands.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx    <= '0;
            ry    <= '0;
            rw    <= '0;
            rh    <= '0;
            color <= RST_COLOR;
            bg    <= BG_BARS;
        end else if (fb) begin
            rx    <= sh_rx;
            ry    <= sh_ry;
            rw    <= sh_rw;
            rh    <= sh_rh;
            color <= sh_color;
            bg    <= sh_bg;
        end
    end

endmodule

// File: rtl/vga_pixel_pipe.sv
// rtl/vga_pixel_pipe.sv - two-tick pixel colour pipeline with shadowed rectangle overlay
// Optional rectangle blink (64-frame period) enabled by defining VGA_PIXEL_BLINK_EN.
module vga_pixel_pipe
    import vga_pkg::*;
#(
    parameter int         HD        = vga_pkg::HD,
    parameter int         VD        = vga_pkg::VD,
    parameter int         PIPE      = 2,
    parameter logic [7:0] RST_COLOR = 8'hE0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 p_tick,
    input  logic [COORD_W-1:0]   pixel_x,
    input  logic [COORD_W-1:0]   pixel_y,
    input  logic                 video_on,
    input  logic                 hsync_in,
    input  logic                 vsync_in,
    input  logic                 wr_req,
    input  logic [2:0]           wr_addr,
    input  logic [COORD_W-1:0]   wr_data,
    output logic                 wr_ack,
    output logic                 wr_err,
    output logic [RGB_W-1:0]     rgb,
    output logic                 hsync,
    output logic                 vsync,
    output logic [7:0]           frame_cnt
);

    logic                fb;
    logic [COORD_W-1:0]  rx, ry, rw, rh;
    logic [RGB_W-1:0]    color;
    logic [1:0]          bg;

    logic [COORD_W-1:0]  s1_x, s1_y;
    logic                s1_von;
    logic [PIPE-1:0]     hs_sr, vs_sr;

    logic [COORD_W:0]    rx_end, ry_end;
    logic                in_x, in_y, in_rect, draw_rect;
    logic [RGB_W-1:0]    pix_color;

    assign fb = p_tick && (pixel_x == '0) && (pixel_y == COORD_W'(VD));

    vga_reg_if #(
        .RST_COLOR (RST_COLOR)
    ) u_reg_if (
        .clk     (clk),
        .reset   (reset),
        .fb      (fb),
        .wr_req  (wr_req),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .wr_ack  (wr_ack),
        .wr_err  (wr_err),
        .rx      (rx),
        .ry      (ry),
        .rw      (rw),
        .rh      (rh),
        .color   (color),
        .bg      (bg)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) frame_cnt <= '0;
        else if (fb) frame_cnt <= frame_cnt + 8'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_x   <= '0;
            s1_y   <= '0;
            s1_von <= 1'b0;
        end else if (p_tick) begin
            s1_x   <= pixel_x;
            s1_y   <= pixel_y;
            s1_von <= video_on;
        end
    end

    // Bit 0 is stage 1, bit PIPE-1 drives the pin; sync idles high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hs_sr <= '1;
            vs_sr <= '1;
        end else if (p_tick) begin
            hs_sr <= {hs_sr[PIPE-2:0], hsync_in};
            vs_sr <= {vs_sr[PIPE-2:0], vsync_in};
        end
    end

    assign hsync = hs_sr[PIPE-1];
    assign vsync = vs_sr[PIPE-1];

    // Extent sums carry an extra bit so an edge near 1023 cannot wrap to x=0.
    assign rx_end  = {1'b0, rx} + {1'b0, rw};
    assign ry_end  = {1'b0, ry} + {1'b0, rh};
    assign in_x    = (s1_x >= rx) && ({1'b0, s1_x} < rx_end);
    assign in_y    = (s1_y >= ry) && ({1'b0, s1_y} < ry_end);
    assign in_rect = (rw != '0) && (rh != '0) && in_x && in_y;

`ifdef VGA_PIXEL_BLINK_EN
    assign draw_rect = in_rect && !frame_cnt[5];
`else
    assign draw_rect = in_rect;
`endif

    always_comb begin
        pix_color = '0;
        if (!s1_von) begin
            pix_color = '0;
        end else if (draw_rect) begin
            pix_color = color;
        end else begin
            case (bg_mode_t'(bg))
                BG_BARS:  pix_color = bar_color(s1_x, HD / 8);
                BG_CHECK: pix_color = (s1_x[5] ^ s1_y[5]) ? BAR_WHITE : BAR_BLACK;
                default:  pix_color = BAR_BLACK;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rgb <= '0;
        else if (p_tick) rgb <= pix_color;
    end

endmodule

// File: tb/tb_vga_pixel_pipe.sv
// tb/tb_vga_pixel_pipe.sv - table-driven and scoreboard bench for vga_pixel_pipe
module tb_vga_pixel_pipe;

    localparam int VD = 480;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       p_tick = 1'b0;
    logic [9:0] pixel_x = '0;
    logic [9:0] pixel_y = '0;
    logic       video_on = 1'b0;
    logic       hsync_in = 1'b1;
    logic       vsync_in = 1'b1;
    logic       wr_req = 1'b0;
    logic [2:0] wr_addr = '0;
    logic [9:0] wr_data = '0;
    logic       wr_ack, wr_err, hsync, vsync;
    logic [7:0] rgb, frame_cnt;

    always #5 clk = ~clk;

    vga_pixel_pipe dut (
        .clk       (clk),
        .reset     (reset),
        .p_tick    (p_tick),
        .pixel_x   (pixel_x),
        .pixel_y   (pixel_y),
        .video_on  (video_on),
        .hsync_in  (hsync_in),
        .vsync_in  (vsync_in),
        .wr_req    (wr_req),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_ack    (wr_ack),
        .wr_err    (wr_err),
        .rgb       (rgb),
        .hsync     (hsync),
        .vsync     (vsync),
        .frame_cnt (frame_cnt)
    );

    typedef struct {
        logic [9:0] x;
        logic [9:0] y;
        logic       von;
        logic [7:0] rgb;
    } vec_t;

    localparam logic [7:0] BARS [8] = '{8'hFF, 8'hFC, 8'h1F, 8'h1C, 8'hE3, 8'hE0, 8'h03, 8'h00};

    vec_t       vec [33];
    int         checks = 0;
    int         errors = 0;
    logic [9:0] exp_q [$];
    logic [9:0] m_sh  [6];
    logic [9:0] m_act [6];
    logic [7:0] m_fc;

    function automatic vec_t mk(input int x, input int y, input logic von, input logic [7:0] c);
        vec_t v;
        v.x = 10'(x);
        v.y = 10'(y);
        v.von = von;
        v.rgb = c;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_sh[i] = '0;
        m_sh[4] = 10'h0E0;
        m_sh[5] = 10'h001;
        m_act   = m_sh;
        m_fc    = '0;
    endtask

    function automatic logic [7:0] model_rgb(input logic [9:0] x, input logic [9:0] y, input logic von);
        int  xi = int'(x);
        int  yi = int'(y);
        int  k;
        bit  in_r;
        if (!von) return 8'h00;
        in_r = (m_act[2] != 0) && (m_act[3] != 0) &&
               xi >= int'(m_act[0]) && xi < int'(m_act[0]) + int'(m_act[2]) &&
               yi >= int'(m_act[1]) && yi < int'(m_act[1]) + int'(m_act[3]);
`ifdef VGA_PIXEL_BLINK_EN
        if (m_fc[5]) in_r = 0;
`endif
        if (in_r) return m_act[4][7:0];
        case (m_act[5][1:0])
            2'd1: begin
                k = xi / 80;
                if (k > 7) k = 7;
                return BARS[k];
            end
            2'd2:    return (x[5] ^ y[5]) ? 8'hFF : 8'h00;
            default: return 8'h00;
        endcase
    endfunction

    task automatic seed_pipe();
        exp_q.delete();
        exp_q.push_back({8'h00, 1'b1, 1'b1});
    endtask

    // One pixel tick followed by one idle clk; entered and left at a negedge.
    task automatic pix(input int x, input int y, input logic von, input logic hs,
                       input logic vs, input logic [7:0] er);
        logic [9:0] e;
        bit         is_fb;
        pixel_x  = 10'(x);
        pixel_y  = 10'(y);
        video_on = von;
        hsync_in = hs;
        vsync_in = vs;
        p_tick   = 1'b1;
        is_fb    = (x == 0) && (y == VD);
        exp_q.push_back({er, hs, vs});
        @(posedge clk);
        if (is_fb) begin
            m_act = m_sh;
            m_fc  = m_fc + 8'd1;
        end
        @(negedge clk);
        p_tick = 1'b0;
        e = exp_q.pop_front();
        chk("pixel_out", {22'd0, rgb, hsync, vsync}, {22'd0, e});
        @(negedge clk);
    endtask

    task automatic pixm(input int x, input int y, input logic von, input logic hs, input logic vs);
        pix(x, y, von, hs, vs, model_rgb(10'(x), 10'(y), von));
    endtask

    task automatic fb_pix();
        pix(0, VD, 1'b0, 1'b1, 1'b1, 8'h00);
    endtask

    task automatic run_vec(input int lo, input int hi);
        for (int i = lo; i <= hi; i++)
            pix(int'(vec[i].x), int'(vec[i].y), vec[i].von, 1'b1, 1'b1, vec[i].rgb);
    endtask

    task automatic wr(input logic [2:0] a, input logic [9:0] d);
        logic ill;
        ill     = (a > 3'd5);
        wr_req  = 1'b1;
        wr_addr = a;
        wr_data = d;
        @(negedge clk);
        chk("wr_ack_set", {31'd0, wr_ack}, 32'd1);
        chk("wr_err_set", {31'd0, wr_err}, {31'd0, ill});
        wr_data = ~d;
        wr_addr = 3'd6 - a;
        @(negedge clk);
        chk("wr_ack_hold", {31'd0, wr_ack}, 32'd1);
        chk("wr_err_hold", {31'd0, wr_err}, {31'd0, ill});
        wr_req = 1'b0;
        @(negedge clk);
        chk("wr_ack_clr", {31'd0, wr_ack}, 32'd0);
        chk("wr_err_clr", {31'd0, wr_err}, 32'd0);
        if (!ill) m_sh[a] = (a == 3'd4) ? {2'b00, d[7:0]} : (a == 3'd5) ? {8'd0, d[1:0]} : d;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_rgb"}, {24'd0, rgb}, 32'd0);
        chk({tag, "_hsync"}, {31'd0, hsync}, 32'd1);
        chk({tag, "_vsync"}, {31'd0, vsync}, 32'd1);
        chk({tag, "_wr_ack"}, {31'd0, wr_ack}, 32'd0);
        chk({tag, "_wr_err"}, {31'd0, wr_err}, 32'd0);
        chk({tag, "_frame_cnt"}, {24'd0, frame_cnt}, 32'd0);
    endtask

    initial begin
        vec[0]  = mk(0,   0, 1, 8'hFF);  vec[1]  = mk(79,  0, 1, 8'hFF);
        vec[2]  = mk(80,  0, 1, 8'hFC);  vec[3]  = mk(159, 0, 1, 8'hFC);
        vec[4]  = mk(160, 0, 1, 8'h1F);  vec[5]  = mk(319, 0, 1, 8'h1C);
        vec[6]  = mk(320, 0, 1, 8'hE3);  vec[7]  = mk(479, 0, 1, 8'hE0);
        vec[8]  = mk(480, 0, 1, 8'h03);  vec[9]  = mk(639, 0, 1, 8'h00);
        vec[10] = mk(300, 0, 0, 8'h00);
        vec[11] = mk(100, 50, 1, 8'hFC); vec[12] = mk(119, 59, 1, 8'hFC);
        vec[13] = mk(99,  50, 1, 8'hFC); vec[14] = mk(100, 50, 1, 8'h1C);
        vec[15] = mk(119, 50, 1, 8'h1C); vec[16] = mk(120, 50, 1, 8'hFC);
        vec[17] = mk(100, 59, 1, 8'h1C); vec[18] = mk(100, 49, 1, 8'hFC);
        vec[19] = mk(100, 60, 1, 8'hFC); vec[20] = mk(110, 55, 0, 8'h00);
        vec[21] = mk(0,  200, 1, 8'h00); vec[22] = mk(32, 200, 1, 8'hFF);
        vec[23] = mk(32, 224, 1, 8'h00); vec[24] = mk(0,  224, 1, 8'hFF);
        vec[25] = mk(32, 200, 1, 8'h00); vec[26] = mk(0,  224, 1, 8'h00);
        vec[27] = mk(629, 50, 1, 8'h00); vec[28] = mk(630, 50, 1, 8'h1C);
        vec[29] = mk(639, 59, 1, 8'h1C); vec[30] = mk(0,   50, 1, 8'hFF);
        vec[31] = mk(39,  55, 1, 8'hFF); vec[32] = mk(40,  50, 1, 8'hFF);

        model_reset();
        repeat (3) @(negedge clk);
        chk_reset("por");
        reset = 1'b1;
        seed_pipe();

        run_vec(0, 10);
        for (int x = 0; x < 640; x++) pixm(x, 1, 1'b1, 1'b1, 1'b1);
        for (int x = 640; x < 672; x++) pixm(x, 1, 1'b0, (x >= 650 && x < 660) ? 1'b0 : 1'b1, 1'b1);

        wr(3'd6, 10'h3FF);
        wr(3'd7, 10'h000);

        wr(3'd0, 10'd100); wr(3'd1, 10'd50); wr(3'd2, 10'd20); wr(3'd3, 10'd10);
        wr(3'd4, 10'h01C);
        run_vec(11, 12);
        fb_pix();
        chk("frame_cnt_first_fb", {24'd0, frame_cnt}, 32'd1);
        run_vec(13, 20);

        wr(3'd5, 10'd2); fb_pix(); run_vec(21, 24);
        wr(3'd5, 10'd3); fb_pix(); run_vec(25, 26);
        wr(3'd5, 10'd1); wr(3'd0, 10'd630); wr(3'd2, 10'd50); fb_pix(); run_vec(27, 32);

        // Write lands on the same edge as the frame boundary.
        wr_req  = 1'b1;
        wr_addr = 3'd4;
        wr_data = 10'h003;
        fb_pix();
        chk("same_edge_ack", {31'd0, wr_ack}, 32'd1);
        wr_req = 1'b0;
        @(negedge clk);
        chk("same_edge_ack_clr", {31'd0, wr_ack}, 32'd0);
        m_sh[4] = 10'h003;
        pix(630, 50, 1'b1, 1'b1, 1'b1, 8'h1C);
        fb_pix();
        pix(630, 50, 1'b1, 1'b1, 1'b1, 8'h03);

        for (int f = 0; f < 260; f++) begin
            fb_pix();
            chk("frame_cnt", {24'd0, frame_cnt}, {24'd0, m_fc});
            pixm(635, 52, 1'b1, 1'b1, 1'b1);
        end
        chk("frame_cnt_wrapped", {24'd0, frame_cnt}, 32'd10);

        pixm(632, 50, 1'b1, 1'b1, 1'b1);
        pixm(633, 51, 1'b1, 1'b0, 1'b0);
        wr_req  = 1'b1;
        wr_addr = 3'd0;
        wr_data = 10'd5;
        @(negedge clk);
        chk("pre_reset_ack", {31'd0, wr_ack}, 32'd1);
        #2 reset = 1'b0;
        #1 chk_reset("mid");
        wr_req = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        seed_pipe();
        for (int x = 0; x < 8; x++)
            pixm(x, 0, 1'b1, (x >= 2 && x < 5) ? 1'b0 : 1'b1, (x < 3) ? 1'b0 : 1'b1);
        pixm(8, 0, 1'b0, 1'b1, 1'b1);
        chk("post_reset_frame_cnt", {24'd0, frame_cnt}, 32'd0);
        chk("post_reset_wr_ack", {31'd0, wr_ack}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
